// File: rtl/axis_token_shaper_if.sv
// Control pair and output-stream snoop shared between a packet gater and its rate shaper.
// master = shaper side (issues grants, observes beats); slave = gater side.
interface axis_token_shaper_if #(
    parameter int unsigned AXIS_BYTES = 1
);
    logic                  c_pass;
    logic                  c_ready;
    logic                  mon_tvalid;
    logic                  mon_tready;
    logic                  mon_tlast;
    logic [AXIS_BYTES-1:0] mon_tkeep;

    modport master (
        output c_pass,
        input  c_ready,
        input  mon_tvalid,
        input  mon_tready,
        input  mon_tlast,
        input  mon_tkeep
    );

    modport slave (
        input  c_pass,
        output c_ready,
        output mon_tvalid,
        output mon_tready,
        output mon_tlast,
        output mon_tkeep
    );
endinterface

// File: rtl/axis_token_shaper.sv
// Byte-based token-bucket shaper: grants one packet at a time while the bucket is non-negative
// and debits the bucket by the bytes seen leaving the gater.
module axis_token_shaper #(
    parameter int unsigned AXIS_BYTES  = 1,
    parameter int unsigned TOKEN_BITS  = 16,
    parameter int unsigned PERIOD_BITS = 16
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         cfg_enable_i,
    input  logic [PERIOD_BITS-1:0]       cfg_period_i,
    input  logic [TOKEN_BITS-1:0]        cfg_refill_i,
    input  logic [TOKEN_BITS-1:0]        cfg_max_i,
    axis_token_shaper_if.master          gate_io,
    output logic signed [TOKEN_BITS:0]   stat_tokens_o,
    output logic [31:0]                  stat_pkts_o
);
    localparam int unsigned CntW = $clog2(AXIS_BYTES + 1);
    localparam int unsigned SumW = TOKEN_BITS + 3;

    typedef enum logic [0:0] {StIdle, StGrantWait} state_e;

    state_e                    state_q, state_d;
    logic [PERIOD_BITS-1:0]    period_cnt_q, period_cnt_d;
    logic signed [TOKEN_BITS:0] bucket_q, bucket_d;
    logic [31:0]               pkts_q, pkts_d;

    logic                      beat;
    logic                      pass;
    logic                      refill_now;
    logic [PERIOD_BITS-1:0]    period_eff;
    logic [CntW-1:0]           keep_cnt;
    logic signed [SumW-1:0]    sum, lim_hi, lim_lo;

    assign beat = gate_io.mon_tvalid & gate_io.mon_tready;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < AXIS_BYTES; i++) begin
            keep_cnt = keep_cnt + CntW'(gate_io.mon_tkeep[i]);
        end
    end

    // A zero period behaves like one: refill on every cycle.
    always_comb begin
        period_eff   = (cfg_period_i == '0) ? PERIOD_BITS'(1) : cfg_period_i;
        refill_now   = (period_cnt_q >= period_eff - PERIOD_BITS'(1));
        period_cnt_d = refill_now ? '0 : period_cnt_q + PERIOD_BITS'(1);
    end

    // Net refill and debit first, then a single clamp to [-2^TOKEN_BITS, cfg_max].
    always_comb begin
        sum = {{2{bucket_q[TOKEN_BITS]}}, bucket_q};
        if (refill_now) begin
            sum = sum + $signed({3'b000, cfg_refill_i});
        end
        if (beat) begin
            sum = sum - $signed({{(SumW - CntW){1'b0}}, keep_cnt});
        end
        lim_hi = $signed({3'b000, cfg_max_i});
        lim_lo = $signed({3'b111, {TOKEN_BITS{1'b0}}});
        if (sum > lim_hi) begin
            bucket_d = {1'b0, cfg_max_i};
        end else if (sum < lim_lo) begin
            bucket_d = {1'b1, {TOKEN_BITS{1'b0}}};
        end else begin
            bucket_d = sum[TOKEN_BITS:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pkts_d  = pkts_q;
        pass    = !areset && (state_q == StIdle) && cfg_enable_i && !bucket_q[TOKEN_BITS] &&
                  gate_io.c_ready;
        unique case (state_q)
            StIdle: begin
                if (pass) begin
                    state_d = StGrantWait;
                end
            end
            StGrantWait: begin
                if (beat && gate_io.mon_tlast) begin
                    state_d = StIdle;
                    pkts_d  = pkts_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            period_cnt_q <= '0;
            bucket_q     <= '0;
            pkts_q       <= '0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            bucket_q     <= bucket_d;
            pkts_q       <= pkts_d;
        end
    end

    assign gate_io.c_pass = pass;
    assign stat_tokens_o  = bucket_q;
    assign stat_pkts_o    = pkts_q;
endmodule
